// File: rtl/serial_101_tx_if.sv
// Load handshake and serial output bundle for serial_101_tx.
// The transmitter uses the slave modport; whatever feeds it words uses the master modport.
interface serial_101_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             d;
  logic             d_valid;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, d, d_valid, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, d, d_valid, done
  );
endinterface

// File: rtl/serial_101_tx.sv
// Serial frame transmitter: "101" preamble, payload MSB-first, optional even parity, idle gap.
// Define SERIAL_101_TX_PARITY_EN to append the even-parity bit after the payload.
module serial_101_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  serial_101_tx_if.slave bus
);
  localparam int unsigned MAX_CNT = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
  localparam int unsigned CW_RAW  = $clog2(MAX_CNT + 1);
  // The preamble counter must reach 2 even for the smallest WIDTH/GAP_CYCLES.
  localparam int unsigned CW      = (CW_RAW < 2) ? 2 : CW_RAW;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
`ifdef SERIAL_101_TX_PARITY_EN
    PAR,
`endif
    GAP
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             d_q, d_n;
  logic             dv_q, dv_n;
  logic             done_q, done_n;
  logic             ready_q, ready_n;
`ifdef SERIAL_101_TX_PARITY_EN
  logic             par_q, par_n;
`endif

  // Next state plus the output values that state will present after the edge.
  always_comb begin
    state_n = state_q;
    sh_n    = sh_q;
    cnt_n   = cnt_q;
    d_n     = 1'b0;
    dv_n    = 1'b0;
    done_n  = 1'b0;
    ready_n = 1'b0;
`ifdef SERIAL_101_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state_q)
      IDLE: begin
        ready_n = 1'b1;
        if (bus.load_valid) begin
          sh_n    = bus.load_data;
          cnt_n   = '0;
          state_n = PRE;
          ready_n = 1'b0;
          dv_n    = 1'b1;
          d_n     = 1'b1;
`ifdef SERIAL_101_TX_PARITY_EN
          par_n   = ^bus.load_data;
`endif
        end
      end
      PRE: begin
        dv_n = 1'b1;
        if (cnt_q == CW'(2)) begin
          state_n = DATA;
          cnt_n   = '0;
          d_n     = sh_q[WIDTH-1];
        end else begin
          cnt_n = cnt_q + CW'(1);
          d_n   = (cnt_q == CW'(1));
        end
      end
      DATA: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_n = '0;
`ifdef SERIAL_101_TX_PARITY_EN
          state_n = PAR;
          dv_n    = 1'b1;
          d_n     = par_q;
`else
          state_n = GAP;
          done_n  = 1'b1;
`endif
        end else begin
          cnt_n = cnt_q + CW'(1);
          sh_n  = sh_q << 1;
          dv_n  = 1'b1;
          d_n   = sh_n[WIDTH-1];
        end
      end
`ifdef SERIAL_101_TX_PARITY_EN
      PAR: begin
        state_n = GAP;
        cnt_n   = '0;
        done_n  = 1'b1;
      end
`endif
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef SERIAL_101_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      sh_q    <= sh_n;
      cnt_q   <= cnt_n;
      d_q     <= d_n;
      dv_q    <= dv_n;
      done_q  <= done_n;
      ready_q <= ready_n;
`ifdef SERIAL_101_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.d          = d_q;
  assign bus.d_valid    = dv_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_serial_101_tx.sv
// Scoreboard bench for serial_101_tx: expected frames are queued at drive time and
// compared bit-for-bit when the transmitter signals done.
module tb_serial_101_tx;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned GAP   = 2;
`ifdef SERIAL_101_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FLEN   = 3 + WIDTH + PBITS;
  localparam int unsigned PERIOD = FLEN + GAP + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_101_tx_if #(.WIDTH(WIDTH)) bus ();

  serial_101_tx #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dones    = 0;
  int n_sent   = 0;

  logic [63:0] exp_q[$];
  int          starts[$];
  logic [63:0] cur = '0;
  int          nbits = 0;
  logic        prev_dv = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference frame: 101, payload MSB-first, then the count-of-ones parity when enabled.
  function automatic logic [63:0] frame_of(input logic [WIDTH-1:0] w);
    logic [63:0] f;
    int ones;
    f = 64'(3'b101);
    ones = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      f = {f[62:0], w[i]};
      if (w[i]) ones++;
    end
`ifdef SERIAL_101_TX_PARITY_EN
    f = {f[62:0], 1'((ones % 2) != 0)};
`endif
    return f;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: collect valid bits into a frame, compare on done.
  always @(negedge clk) begin
    if (rst) begin
      cur     = '0;
      nbits   = 0;
      prev_dv = 1'b0;
    end else begin
      if (bus.d_valid) begin
        if (!prev_dv) starts.push_back(cyc);
        cur = {cur[62:0], bus.d};
        nbits++;
      end else begin
        check_eq("d_idle_zero", 64'(bus.d), 64'(0));
      end
      if (prev_dv && !bus.d_valid) check_eq("done_at_frame_end", 64'(bus.done), 64'(1));
      if (bus.done) begin
        dones++;
        check_eq("done_dv_low", 64'(bus.d_valid), 64'(0));
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 64'(exp_q.size()), 64'(1));
        end else begin
          check_eq("frame_bits", cur, exp_q.pop_front());
          check_eq("frame_len", 64'(nbits), 64'(FLEN));
        end
        cur   = '0;
        nbits = 0;
      end
      prev_dv = bus.d_valid;
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.load_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check_eq("ready_timeout", 64'(bus.load_ready), 64'(1));
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input bit expect_frame);
    wait_ready();
    bus.load_data  = w;
    bus.load_valid = 1'b1;
    if (expect_frame) begin
      exp_q.push_back(frame_of(w));
      n_sent++;
    end
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (GAP + 2) @(negedge clk);
  endtask

  initial begin
    int s0;
    int d0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_d", 64'(bus.d), 64'(0));
    check_eq("rst_dv", 64'(bus.d_valid), 64'(0));
    check_eq("rst_done", 64'(bus.done), 64'(0));
    check_eq("rst_ready", 64'(bus.load_ready), 64'(1));
    rst = 1'b0;

    // 0xA5 frame, with first-bit latency of one cycle
    send(8'hA5, 1'b1);
    @(negedge clk);
    check_eq("first_bit_d", 64'(bus.d), 64'(1));
    check_eq("first_bit_dv", 64'(bus.d_valid), 64'(1));
    check_eq("busy_ready", 64'(bus.load_ready), 64'(0));
    @(negedge clk);
    check_eq("second_pre_bit", 64'(bus.d), 64'(0));
    wait_idle();

    // Parity corner words
    send(8'h01, 1'b1);
    wait_idle();
    send(8'hFF, 1'b1);
    wait_idle();

    // Load attempt while busy is ignored
    send(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    bus.load_data  = 8'h3C;
    bus.load_valid = 1'b1;
    check_eq("busy_ignore_ready", 64'(bus.load_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    wait_idle();

    // Back-to-back with load_valid held
    wait_ready();
    s0 = starts.size();
    d0 = dones;
    bus.load_data  = 8'h0F;
    bus.load_valid = 1'b1;
    exp_q.push_back(frame_of(8'h0F));
    exp_q.push_back(frame_of(8'hF0));
    n_sent += 2;
    @(posedge clk);
    #1;
    bus.load_data = 8'hF0;
    wait_ready();
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    wait_idle();
    check_eq("b2b_frames", 64'(starts.size() - s0), 64'(2));
    if (starts.size() >= s0 + 2)
      check_eq("b2b_period", 64'(starts[s0 + 1] - starts[s0]), 64'(PERIOD));
    check_eq("b2b_dones", 64'(dones - d0), 64'(2));

    // Reset on the 4th payload bit aborts the frame
    send(8'h96, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_d", 64'(bus.d), 64'(0));
    check_eq("abort_dv", 64'(bus.d_valid), 64'(0));
    check_eq("abort_done", 64'(bus.done), 64'(0));
    check_eq("abort_ready", 64'(bus.load_ready), 64'(1));
    d0 = dones;
    repeat (20) @(negedge clk);
    check_eq("abort_no_done", 64'(dones), 64'(d0));
    send(8'h3A, 1'b1);
    wait_idle();

    // Reset wins over a simultaneous load
    @(negedge clk);
    rst            = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h55;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rstwin_dv", 64'(bus.d_valid), 64'(0));
      check_eq("rstwin_ready", 64'(bus.load_ready), 64'(1));
    end

    repeat (PERIOD) @(negedge clk);
    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
    check_eq("total_dones", 64'(dones), 64'(n_sent));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
